// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_to_reg;
    logic pc_src;
  } stage_tag_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_e;

  // Highest register index, which is the architectural PC.
  function automatic int unsigned pc_idx(input int unsigned reg_w);
    pc_idx = (32'd1 << reg_w) - 32'd1;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage tag record: control flags plus a stage-specific payload
// (destination tag, and for Execute also the source tags and used bits).
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter int unsigned PW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  stage_tag_t    tag_d,
  input  logic [PW-1:0] pay_d,
  output stage_tag_t    tag_q,
  output logic [PW-1:0] pay_q
);

  stage_tag_t    tag_r;
  logic [PW-1:0] pay_r;

  // Record update: clear beats load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      tag_r <= '0;
      pay_r <= '0;
    end else if (en) begin
      tag_r <= tag_d;
      pay_r <= pay_d;
    end else begin
      tag_r <= tag_r;
      pay_r <= pay_r;
    end
  end

  assign tag_q = tag_r;
  assign pay_q = pay_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: tracks E/M/W destination tags and derives
// forwarding selects, load-use and PC-write stalls, flushes and MUL occupancy.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NSRC    = 3,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSRC*REG_W-1:0]   RAD,
  input  logic [NSRC-1:0]         RAUsedD,
  input  logic [REG_W-1:0]        WA3D,
  input  logic                    RegWriteD,
  input  logic                    MemtoRegD,
  input  logic                    PCSrcD,
  input  logic                    MultiCycleD,
  input  logic                    BranchTakenE,
  output logic [2*NSRC-1:0]       ForwardE,
  output logic                    StallF,
  output logic                    StallD,
  output logic                    StallE,
  output logic                    FlushD,
  output logic                    FlushE,
  output logic                    BusyE
);

  localparam int unsigned      EPW      = REG_W + NSRC*REG_W + NSRC;
  localparam int unsigned      CNT_W    = (MUL_LAT > 32'd1) ? $clog2(MUL_LAT) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MUL_LAT > 32'd1) ? (MUL_LAT - 32'd1) : 32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic             MC_EN    = (MUL_LAT > 32'd1);
  localparam logic [REG_W-1:0] PC_IDX   = REG_W'(pc_idx(REG_W));

  stage_tag_t            d_tag_s, e_tag_s, m_tag_s, w_tag_s;
  logic [EPW-1:0]        e_pay_s;
  logic [REG_W-1:0]      e_wa3_s, m_wa3_s, w_wa3_s;
  logic [NSRC*REG_W-1:0] e_ra_s;
  logic [NSRC-1:0]       e_used_s;
  logic                  ld_hit_s, ld_stall_s, pc_wr_pend_s, busy_s;
  logic                  flush_e_s, e_load_s, mc_start_s;
  logic [1:0]            unused_w_s;
  mc_state_e             state_r;
  logic [CNT_W-1:0]      cnt_r;

  assign d_tag_s = '{valid: 1'b1, reg_write: RegWriteD, mem_to_reg: MemtoRegD, pc_src: PCSrcD};

  assign e_wa3_s  = e_pay_s[EPW-1 -: REG_W];
  assign e_ra_s   = e_pay_s[NSRC +: NSRC*REG_W];
  assign e_used_s = e_pay_s[NSRC-1:0];

  // Execute holds while a multi-cycle op occupies it; a flush turns it into a bubble.
  hazard_stage_reg #(.PW(EPW)) u_stage_e (
    .clk   (clk),
    .reset (reset),
    .en    (~busy_s),
    .clr   (flush_e_s),
    .tag_d (d_tag_s),
    .pay_d ({WA3D, RAD, RAUsedD}),
    .tag_q (e_tag_s),
    .pay_q (e_pay_s)
  );

  hazard_stage_reg #(.PW(REG_W)) u_stage_m (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (busy_s),
    .tag_d (e_tag_s),
    .pay_d (e_wa3_s),
    .tag_q (m_tag_s),
    .pay_q (m_wa3_s)
  );

  hazard_stage_reg #(.PW(REG_W)) u_stage_w (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .tag_d (m_tag_s),
    .pay_d (m_wa3_s),
    .tag_q (w_tag_s),
    .pay_q (w_wa3_s)
  );

  // Writeback load/PC flags have no consumer here.
  assign unused_w_s = {w_tag_s.mem_to_reg, w_tag_s.pc_src};

  // Load-use: any read operand in Decode hits the load currently in Execute.
  always_comb begin
    ld_hit_s = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (RAUsedD[i] && (RAD[i*REG_W +: REG_W] == e_wa3_s)) begin
        ld_hit_s = 1'b1;
      end else begin
        ld_hit_s = ld_hit_s;
      end
    end
    ld_stall_s = ld_hit_s & e_tag_s.valid & e_tag_s.mem_to_reg & e_tag_s.reg_write;
  end

  // Per-operand forwarding select; Memory wins over Writeback, PC never forwards.
  always_comb begin
    ForwardE = {(2*NSRC){1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if (!e_used_s[i] || (e_ra_s[i*REG_W +: REG_W] == PC_IDX)) begin
        ForwardE[2*i +: 2] = FWD_RF;
      end else if (m_tag_s.valid && m_tag_s.reg_write && (m_wa3_s == e_ra_s[i*REG_W +: REG_W])) begin
        ForwardE[2*i +: 2] = FWD_M;
      end else if (w_tag_s.valid && w_tag_s.reg_write && (w_wa3_s == e_ra_s[i*REG_W +: REG_W])) begin
        ForwardE[2*i +: 2] = FWD_W;
      end else begin
        ForwardE[2*i +: 2] = FWD_RF;
      end
    end
  end

  assign busy_s       = (state_r == ST_BUSY);
  assign pc_wr_pend_s = PCSrcD | (e_tag_s.valid & e_tag_s.pc_src) | (m_tag_s.valid & m_tag_s.pc_src);
  assign flush_e_s    = (ld_stall_s | BranchTakenE) & ~busy_s;
  assign e_load_s     = ~busy_s & ~flush_e_s;
  assign mc_start_s   = MC_EN & e_load_s & MultiCycleD;

  assign StallF = ld_stall_s | pc_wr_pend_s | busy_s;
  assign StallD = ld_stall_s | busy_s;
  assign StallE = busy_s;
  assign FlushD = pc_wr_pend_s | (BranchTakenE & ~busy_s);
  assign FlushE = flush_e_s;
  assign BusyE  = busy_s;

  // Multi-cycle occupancy: count down the remaining Execute cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mc_start_s) begin
            state_r <= ST_BUSY;
            cnt_r   <= CNT_INIT;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        ST_BUSY: begin
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each cycle's expected outputs are queued as
// the Decode/Execute inputs are driven, then popped and compared mid-cycle.
module tb_hazard_ctrl;

  localparam int unsigned NSRC    = 3;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] RAD;
  logic [2:0]  RAUsedD;
  logic [3:0]  WA3D;
  logic        RegWriteD, MemtoRegD, PCSrcD, MultiCycleD, BranchTakenE;
  logic [5:0]  ForwardE;
  logic        StallF, StallD, StallE, FlushD, FlushE, BusyE;

  hazard_ctrl #(.NSRC(NSRC), .REG_W(REG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .RAD(RAD), .RAUsedD(RAUsedD), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .MultiCycleD(MultiCycleD), .BranchTakenE(BranchTakenE), .ForwardE(ForwardE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
    .FlushE(FlushE), .BusyE(BusyE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       br;
    logic [3:0] ra2, ra1, ra0;
    logic [2:0] used;
    logic [3:0] wa;
    logic       rw, mem, pc, mc;
  } stim_t;

  localparam stim_t       NOP = '0;
  localparam logic [11:0] Z   = 12'd0;

  logic [11:0] sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic stim_t ins(input logic [3:0] ra0, input logic [3:0] ra1, input logic [3:0] ra2,
                                input logic [2:0] used, input logic [3:0] wa,
                                input logic rw, input logic mem, input logic pc, input logic mc);
    stim_t s;
    s = '0;
    s.ra0 = ra0; s.ra1 = ra1; s.ra2 = ra2; s.used = used; s.wa = wa;
    s.rw = rw; s.mem = mem; s.pc = pc; s.mc = mc;
    return s;
  endfunction

  function automatic stim_t with_br(input stim_t s);
    s.br = 1'b1;
    return s;
  endfunction

  function automatic stim_t with_rst(input stim_t s);
    s.rst = 1'b1;
    return s;
  endfunction

  // Expected vector {ForwardE, StallF, StallD, StallE, FlushD, FlushE, BusyE}.
  function automatic logic [11:0] ex(input logic [5:0] fwd, input logic sf, input logic sd,
                                     input logic se, input logic fd, input logic fe, input logic bz);
    return {fwd, sf, sd, se, fd, fe, bz};
  endfunction

  function automatic logic [11:0] observed();
    return {ForwardE, StallF, StallD, StallE, FlushD, FlushE, BusyE};
  endfunction

  task automatic drive(input stim_t s);
    reset = s.rst; BranchTakenE = s.br;
    RAD = {s.ra2, s.ra1, s.ra0}; RAUsedD = s.used; WA3D = s.wa;
    RegWriteD = s.rw; MemtoRegD = s.mem; PCSrcD = s.pc; MultiCycleD = s.mc;
  endtask

  task automatic issue(input stim_t s, input logic [11:0] e);
    @(negedge clk);
    drive(s);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(with_rst(NOP));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stim_t st[3];
    logic [11:0] ev[3];
    logic [11:0] exp_v, obs_v;
    st = '{with_rst(NOP), with_rst(ins(4'd3, 4'd5, 4'd0, 3'b011, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0)), NOP};
    ev = '{Z, ex(6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), Z};
    for (int k = 0; k < 3; k++) begin
      issue(st[k], ev[k]);
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset[%0d] got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_forward();
    stim_t st[5];
    logic [11:0] ev[5];
    logic [11:0] exp_v, obs_v;
    st = '{ins(4'd5, 4'd6, 4'd0, 3'b011, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0),
           ins(4'd1, 4'd3, 4'd0, 3'b011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0),
           NOP,
           ins(4'd2, 4'd1, 4'd0, 3'b011, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0),
           NOP};
    ev = '{Z, Z, ex(6'b000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), Z,
           ex(6'b000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      issue(st[k], ev[k]);
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL forward[%0d] got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_priority();
    stim_t st[4];
    logic [11:0] ev[4];
    logic [11:0] exp_v, obs_v;
    st = '{ins(4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0),
           ins(4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0),
           ins(4'd0, 4'd3, 4'd3, 3'b100, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0),
           NOP};
    ev = '{Z, Z, Z, ex(6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue(st[k], ev[k]);
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL priority[%0d] got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[4];
    logic [11:0] ev[4];
    logic [11:0] exp_v, obs_v;
    st = '{ins(4'd4, 4'd0, 4'd0, 3'b001, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0),
           ins(4'd1, 4'd1, 4'd0, 3'b011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0),
           ins(4'd1, 4'd1, 4'd0, 3'b011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0),
           NOP};
    ev = '{Z, ex(6'b000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), Z,
           ex(6'b000101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue(st[k], ev[k]);
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL load_use[%0d] got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_multicycle();
    stim_t st[6];
    logic [11:0] ev[6];
    logic [11:0] exp_v, obs_v;
    st = '{ins(4'd0, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0),
           ins(4'd2, 4'd4, 4'd0, 3'b011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1),
           ins(4'd4, 4'd0, 4'd0, 3'b001, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0),
           with_br(ins(4'd4, 4'd0, 4'd0, 3'b001, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0)),
           ins(4'd4, 4'd0, 4'd0, 3'b001, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0),
           NOP};
    ev = '{Z, Z,
           ex(6'b000010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1),
           ex(6'b000001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1),
           Z,
           ex(6'b000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      issue(st[k], ev[k]);
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL multicycle[%0d] got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_pc_write();
    stim_t st[4];
    logic [11:0] ev[4];
    logic [11:0] exp_v, obs_v;
    st = '{ins(4'd1, 4'd0, 4'd0, 3'b001, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0),
           ins(4'd15, 4'd15, 4'd15, 3'b111, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0),
           ins(4'd15, 4'd15, 4'd15, 3'b111, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0),
           NOP};
    ev = '{ex(6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
           ex(6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
           ex(6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
           Z};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue(st[k], ev[k]);
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL pc_write[%0d] got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_branch_ldstall();
    stim_t st[4];
    logic [11:0] ev[4];
    logic [11:0] exp_v, obs_v;
    st = '{ins(4'd4, 4'd0, 4'd0, 3'b001, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0),
           with_br(ins(4'd1, 4'd0, 4'd0, 3'b001, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0)),
           ins(4'd1, 4'd0, 4'd0, 3'b001, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0),
           with_br(NOP)};
    ev = '{Z, ex(6'b000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), Z,
           ex(6'b000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue(st[k], ev[k]);
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL branch_ldstall[%0d] got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_busy();
    stim_t st[5];
    logic [11:0] ev[5];
    logic [11:0] exp_v, obs_v;
    st = '{ins(4'd0, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1),
           NOP,
           with_rst(NOP),
           ins(4'd4, 4'd0, 4'd0, 3'b001, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0),
           NOP};
    ev = '{Z,
           ex(6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1),
           ex(6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1),
           Z, Z};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      issue(st[k], ev[k]);
      exp_v = sb_q.pop_front();
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_busy[%0d] got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    drive(with_rst(NOP));
    repeat (2) @(posedge clk);
    test_reset();
    test_forward();
    test_priority();
    test_load_use();
    test_multicycle();
    test_pc_write();
    test_branch_ldstall();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
